// File: rtl/card_dealer_if.sv
// rtl/card_dealer_if.sv - deal request, random nibble and hand signals of the card dealer
//
// Purpose: bundles the game-side and generator-side signals of card_dealer.
// Signals:
//   deal           request a new hand (driven by the game logic)
//   rand_in[3:0]   current nibble from the random generator
//   rand_en        advance enable back to the generator
//   card0..card3   dealt hand, card0 is the first accepted value
//   valid          hand complete and legal (level)
//   busy           dealer is drawing samples
//   err            last deal timed out (level)
// Modports: master = game logic / generator side, slave = dealer side.
interface card_dealer_if;
   logic       deal;
   logic [3:0] rand_in;
   logic       rand_en;
   logic [3:0] card0;
   logic [3:0] card1;
   logic [3:0] card2;
   logic [3:0] card3;
   logic       valid;
   logic       busy;
   logic       err;

   modport master (
      output deal, rand_in,
      input  rand_en, card0, card1, card2, card3, valid, busy, err
   );

   modport slave (
      input  deal, rand_in,
      output rand_en, card0, card1, card2, card3, valid, busy, err
   );
endinterface

// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - rejection-samples a nibble stream into a four-card hand
//
// Purpose: on a deal request, enables the random source and keeps every
// nibble in 1..MAX_VALUE as the next card until four cards are held. If the
// hand is not complete after MAX_TRIES samples the deal ends with err set.
// Ports:
//   clk   system clock, all state on the rising edge
//   rst   asynchronous active-high reset
//   bus   card_dealer_if.slave (deal, rand_in in; rand_en, cards, valid,
//         busy, err out)
// Parameters:
//   MAX_VALUE  largest legal card value (1..15)
//   MAX_TRIES  samples allowed per deal before err (4..255)
module card_dealer #(
   parameter int MAX_VALUE = 9,
   parameter int MAX_TRIES = 64
) (
   input  logic                clk,
   input  logic                rst,
   card_dealer_if.slave        bus
);

   localparam logic [3:0] MAX_V   = 4'(MAX_VALUE);
   localparam logic [8:0] TRY_LIM = 9'(MAX_TRIES);

   typedef enum logic {IDLE, DRAW} state_t;

   state_t     state_q, state_d;
   logic [3:0] card_q [4];
   logic [3:0] card_d [4];
   logic       valid_q, valid_d;
   logic       err_q, err_d;
   logic [2:0] acc_q, acc_d;
   logic [7:0] try_q, try_d;

   logic       accept;
   logic [8:0] try_next;

   always_comb begin
      state_d  = state_q;
      card_d   = card_q;
      valid_d  = valid_q;
      err_d    = err_q;
      acc_d    = acc_q;
      try_d    = try_q;
      accept   = (bus.rand_in != 4'd0) && (bus.rand_in <= MAX_V);
      // One bit wider than the counter so the limit compare cannot alias.
      try_next = {1'b0, try_q} + 9'd1;

      case (state_q)
         IDLE: begin
            if (bus.deal) begin
               state_d = DRAW;
               card_d  = '{default: 4'd0};
               valid_d = 1'b0;
               err_d   = 1'b0;
               acc_d   = 3'd0;
               try_d   = 8'd0;
            end
         end
         DRAW: begin
            try_d = try_next[7:0];
            if (accept) begin
               // acc_q never exceeds 3 while drawing, so two bits index the hand.
               card_d[acc_q[1:0]] = bus.rand_in;
               acc_d              = acc_q + 3'd1;
            end
            // Completion is tested first so a 4th accept on the last allowed
            // sample still yields a valid hand.
            if (accept && (acc_q == 3'd3)) begin
               state_d = IDLE;
               valid_d = 1'b1;
            end else if (try_next == TRY_LIM) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         card_q  <= '{default: 4'd0};
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         acc_q   <= 3'd0;
         try_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         card_q  <= card_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         acc_q   <= acc_d;
         try_q   <= try_d;
      end
   end

   assign bus.rand_en = (state_q == DRAW);
   assign bus.busy    = (state_q == DRAW);
   assign bus.card0   = card_q[0];
   assign bus.card1   = card_q[1];
   assign bus.card2   = card_q[2];
   assign bus.card3   = card_q[3];
   assign bus.valid   = valid_q;
   assign bus.err     = err_q;

endmodule

// File: tb/tb_card_dealer.sv
// tb/tb_card_dealer.sv - self-checking bench for card_dealer (MAX_VALUE 9 and 13)
//
// Purpose: drives deal requests and nibble streams into two dealers sharing
// one stream, and compares their hands against a sampling model.
// Ports: none (top-level bench).
module tb_card_dealer;

   typedef struct packed {
      logic [15:0] cards;
      logic        v;
      logic        e;
      logic [31:0] n;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       deal9 = 1'b0;
   logic       deal13 = 1'b0;
   logic [3:0] rnd = 4'd0;
   int         checks = 0;
   int         errors = 0;
   logic [3:0] stim [$];

   card_dealer_if if9 ();
   card_dealer_if if13 ();

   assign if9.deal     = deal9;
   assign if9.rand_in  = rnd;
   assign if13.deal    = deal13;
   assign if13.rand_in = rnd;

   card_dealer #(.MAX_VALUE(9),  .MAX_TRIES(64)) dut9  (.clk(clk), .rst(rst), .bus(if9.slave));
   card_dealer #(.MAX_VALUE(13), .MAX_TRIES(64)) dut13 (.clk(clk), .rst(rst), .bus(if13.slave));

   always #5 clk = ~clk;

   // Stream value offered before sample i; a starved generator reads as lock-up.
   function automatic logic [3:0] stimval(input int i);
      return (i < stim.size()) ? stim[i] : 4'hf;
   endfunction

   // Walk the stream: keep in-range values, stop at four cards or 64 samples.
   function automatic exp_t model(input int maxv);
      exp_t r;
      int   acc;
      int   val;
      r   = '0;
      acc = 0;
      for (int i = 0; i < 64; i++) begin
         val = int'(stimval(i));
         r.n = 32'(i + 1);
         if (val >= 1 && val <= maxv) begin
            r.cards[acc*4 +: 4] = 4'(val);
            acc++;
            if (acc == 4) begin
               r.v = 1'b1;
               return r;
            end
         end
      end
      r.e = 1'b1;
      return r;
   endfunction

   task automatic run_deal(input string name, input bit use13, input bit poke);
      exp_t e9, e13;
      int   n9, n13, i;
      bit   done9, done13;
      e9  = model(9);
      e13 = model(13);
      @(negedge clk);
      deal9  = 1'b1;
      deal13 = use13;
      rnd    = stimval(0);
      @(negedge clk);
      deal9  = 1'b0;
      deal13 = 1'b0;
      n9 = 0; n13 = 0; done9 = 0; done13 = !use13;
      for (i = 0; i < 300; i++) begin
         if (!if9.busy) done9 = 1;
         if (use13 && !if13.busy) done13 = 1;
         if (done9) deal9 = 1'b0;
         if (done9 && done13) break;
         if (!done9 && if9.rand_en) n9++;
         if (!done13 && if13.rand_en) n13++;
         rnd = stimval(i);
         if (poke && !done9) deal9 = i[0];
         @(negedge clk);
      end
      deal9 = 1'b0;
      checks++;
      if (i >= 300) begin errors++; $display("FAIL %s_bound busy never dropped after %0d cycles, required under 300", name, i); end
      checks++;
      if ({if9.card3, if9.card2, if9.card1, if9.card0} !== e9.cards) begin
         errors++; $display("FAIL %s_cards9 got %h required %h", name, {if9.card3, if9.card2, if9.card1, if9.card0}, e9.cards);
      end
      checks++;
      if (if9.valid !== e9.v) begin errors++; $display("FAIL %s_valid9 got %b required %b", name, if9.valid, e9.v); end
      checks++;
      if (if9.err !== e9.e) begin errors++; $display("FAIL %s_err9 got %b required %b", name, if9.err, e9.e); end
      checks++;
      if (n9 !== int'(e9.n)) begin errors++; $display("FAIL %s_samples9 got %0d required %0d", name, n9, e9.n); end
      if (use13) begin
         checks++;
         if ({if13.card3, if13.card2, if13.card1, if13.card0} !== e13.cards) begin
            errors++; $display("FAIL %s_cards13 got %h required %h", name, {if13.card3, if13.card2, if13.card1, if13.card0}, e13.cards);
         end
         checks++;
         if (if13.valid !== e13.v) begin errors++; $display("FAIL %s_valid13 got %b required %b", name, if13.valid, e13.v); end
         checks++;
         if (if13.err !== e13.e) begin errors++; $display("FAIL %s_err13 got %b required %b", name, if13.err, e13.e); end
         checks++;
         if (n13 !== int'(e13.n)) begin errors++; $display("FAIL %s_samples13 got %0d required %0d", name, n13, e13.n); end
      end
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({if9.card3, if9.card2, if9.card1, if9.card0, if9.valid, if9.err, if9.busy, if9.rand_en} !== 20'd0) begin
         errors++; $display("FAIL reset9 outputs %h required 0", {if9.card3, if9.card2, if9.card1, if9.card0, if9.valid, if9.err, if9.busy, if9.rand_en});
      end
      checks++;
      if ({if13.card3, if13.card2, if13.card1, if13.card0, if13.valid, if13.err, if13.busy, if13.rand_en} !== 20'd0) begin
         errors++; $display("FAIL reset13 outputs %h required 0", {if13.card3, if13.card2, if13.card1, if13.card0, if13.valid, if13.err, if13.busy, if13.rand_en});
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_clean();
      stim = '{4'd3, 4'd5, 4'd7, 4'd9};
      run_deal("clean", 1, 0);
   endtask

   task automatic test_reject();
      stim = '{4'd0, 4'd15, 4'd10, 4'd2, 4'd12, 4'd4, 4'd1, 4'd9};
      run_deal("reject", 1, 0);
   endtask

   task automatic test_timeout();
      stim = {};
      run_deal("lockup", 1, 0);
      stim = '{4'd3, 4'd4, 4'd5};
      run_deal("partial", 1, 0);
   endtask

   task automatic test_boundary();
      // 4th accept exactly on sample 64, then one sample too late.
      stim = {4'd2};
      for (int i = 0; i < 60; i++) stim.push_back(i[0] ? 4'd15 : 4'd0);
      stim.push_back(4'd6); stim.push_back(4'd7); stim.push_back(4'd8);
      run_deal("last_sample", 1, 0);
      stim = {4'd2};
      for (int i = 0; i < 61; i++) stim.push_back(i[0] ? 4'd15 : 4'd0);
      stim.push_back(4'd6); stim.push_back(4'd7); stim.push_back(4'd8);
      run_deal("one_late", 1, 0);
   endtask

   task automatic test_max13();
      stim = '{4'd14, 4'd10, 4'd11, 4'd14, 4'd12, 4'd13};
      run_deal("max13", 1, 0);
   endtask

   task automatic test_ignore();
      stim = '{4'd3, 4'd0, 4'd5, 4'd15, 4'd7, 4'd9};
      run_deal("ignore", 0, 1);
   endtask

   task automatic test_back_to_back();
      logic [3:0] v [8];
      v = '{4'd3, 4'd5, 4'd7, 4'd9, 4'd1, 4'd2, 4'd3, 4'd4};
      @(negedge clk);
      deal9 = 1'b1;
      rnd   = v[0];
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         rnd = v[k];
         @(negedge clk);
      end
      checks++;
      if ({if9.busy, if9.valid, if9.card3, if9.card2, if9.card1, if9.card0} !== {2'b01, 16'h9753}) begin
         errors++; $display("FAIL hold_first got %h required %h", {if9.busy, if9.valid, if9.card3, if9.card2, if9.card1, if9.card0}, {2'b01, 16'h9753});
      end
      @(negedge clk);
      checks++;
      if ({if9.busy, if9.valid, if9.card0} !== {2'b10, 4'd0}) begin
         errors++; $display("FAIL hold_redeal got %h required %h", {if9.busy, if9.valid, if9.card0}, {2'b10, 4'd0});
      end
      deal9 = 1'b0;
      for (int k = 4; k < 8; k++) begin
         rnd = v[k];
         @(negedge clk);
      end
      checks++;
      if ({if9.busy, if9.valid, if9.card3, if9.card2, if9.card1, if9.card0} !== {2'b01, 16'h4321}) begin
         errors++; $display("FAIL hold_second got %h required %h", {if9.busy, if9.valid, if9.card3, if9.card2, if9.card1, if9.card0}, {2'b01, 16'h4321});
      end
   endtask

   task automatic test_abort();
      @(negedge clk);
      deal9 = 1'b1;
      rnd   = 4'd3;
      @(negedge clk);
      deal9 = 1'b0;
      rnd   = 4'd3;
      @(negedge clk);
      rnd = 4'd5;
      @(negedge clk);
      rnd = 4'd15;
      checks++;
      if ({if9.busy, if9.card1, if9.card0} !== {1'b1, 8'h53}) begin
         errors++; $display("FAIL abort_pre got %h required %h", {if9.busy, if9.card1, if9.card0}, {1'b1, 8'h53});
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({if9.card3, if9.card2, if9.card1, if9.card0, if9.valid, if9.err, if9.busy, if9.rand_en} !== 20'd0) begin
         errors++; $display("FAIL abort_rst got %h required 0", {if9.card3, if9.card2, if9.card1, if9.card0, if9.valid, if9.err, if9.busy, if9.rand_en});
      end
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (if9.busy !== 1'b0) begin errors++; $display("FAIL abort_idle busy %b required 0", if9.busy); end
      stim = '{4'd6, 4'd7, 4'd8, 4'd9};
      run_deal("after_abort", 0, 0);
   endtask

   task automatic test_random();
      for (int r = 0; r < 10; r++) begin
         stim = {};
         for (int i = 0; i < 70; i++) begin
            if ($urandom_range(0, 3) == 0) stim.push_back(4'($urandom_range(1, 9)));
            else                           stim.push_back(4'($urandom_range(0, 15)));
         end
         run_deal($sformatf("rand%0d", r), 1, 0);
      end
   endtask

   initial begin
      test_reset();
      test_clean();
      test_reject();
      test_timeout();
      test_boundary();
      test_max13();
      test_ignore();
      test_back_to_back();
      test_abort();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
